img2col_map_sequencer: RTL and testbench

IMG2COL_MAP_SEQUENCER -- requirements
Module: img2col_map_sequencer

---
 rtl/img2col_map_sequencer.sv | 163 ++++++++++++++++
 tb/tb_img2col_map_sequencer.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/img2col_map_sequencer.sv
// rtl/img2col_map_sequencer.sv - IDLE/FILL/RUN counter sequencer for img2col PU buffer mapping
// Optional step counter output enabled by macro MAP_SEQ_STEP_CNT_EN.
module img2col_map_sequencer #(
    parameter int ADDR_DEPTH = 5,
    parameter int NUM_PU     = 28,
    parameter int FILL_ROWS  = 5,
    parameter int NUM_ROUNDS = 28,
    localparam int AW = ($clog2(ADDR_DEPTH) > 1) ? $clog2(ADDR_DEPTH) : 1,
    localparam int PW = ($clog2(NUM_PU)     > 1) ? $clog2(NUM_PU)     : 1,
    localparam int RW = ($clog2(FILL_ROWS)  > 1) ? $clog2(FILL_ROWS)  : 1,
    localparam int NW = ($clog2(NUM_ROUNDS) > 1) ? $clog2(NUM_ROUNDS) : 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          stall,
    input  logic          abort,
    output logic          valid,
    output logic          busy,
    output logic          done,
    output logic [1:0]    phase,
    output logic [AW-1:0] pu_addr,
    output logic [PW-1:0] pu_no,
    output logic [RW-1:0] row_no,
`ifdef MAP_SEQ_STEP_CNT_EN
    output logic [NW-1:0] round_no,
    output logic [31:0]   step_cnt
`else
    output logic [NW-1:0] round_no
`endif
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_FILL = 2'b01,
        ST_RUN  = 2'b10
    } state_t;

    localparam logic [AW-1:0] ADDR_LAST  = AW'(ADDR_DEPTH - 1);
    localparam logic [PW-1:0] PU_LAST    = PW'(NUM_PU - 1);
    localparam logic [RW-1:0] ROW_LAST   = RW'(FILL_ROWS - 1);
    localparam logic [NW-1:0] ROUND_LAST = NW'(NUM_ROUNDS - 1);

    state_t        r_state, w_state_nxt;
    logic [AW-1:0] r_pu_addr, w_pu_addr_nxt;
    logic [PW-1:0] r_pu_no, w_pu_no_nxt;
    logic [RW-1:0] r_row_no, w_row_no_nxt;
    logic [NW-1:0] r_round_no, w_round_no_nxt;
    logic          r_done, w_done_nxt;
    logic          w_busy;
    logic          w_step;
    logic          w_wrap;

    assign w_busy = (r_state != ST_IDLE);
    assign w_step = w_busy & ~stall;
    // a full PU sweep has completed on this step; carries into row/round
    assign w_wrap = (r_pu_addr == ADDR_LAST) && (r_pu_no == PU_LAST);

    always_comb begin
        w_state_nxt    = r_state;
        w_pu_addr_nxt  = r_pu_addr;
        w_pu_no_nxt    = r_pu_no;
        w_row_no_nxt   = r_row_no;
        w_round_no_nxt = r_round_no;
        w_done_nxt     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_pu_addr_nxt  = '0;
                w_pu_no_nxt    = '0;
                w_row_no_nxt   = '0;
                w_round_no_nxt = '0;
                if (start && !abort) begin
                    w_state_nxt = ST_FILL;
                end
            end
            ST_FILL, ST_RUN: begin
                if (abort) begin
                    w_state_nxt    = ST_IDLE;
                    w_pu_addr_nxt  = '0;
                    w_pu_no_nxt    = '0;
                    w_row_no_nxt   = '0;
                    w_round_no_nxt = '0;
                end else if (w_step) begin
                    if (r_pu_addr != ADDR_LAST) begin
                        w_pu_addr_nxt = r_pu_addr + AW'(1);
                    end else begin
                        w_pu_addr_nxt = '0;
                        w_pu_no_nxt   = (r_pu_no == PU_LAST) ? '0 : r_pu_no + PW'(1);
                    end
                    if (w_wrap && r_state == ST_FILL) begin
                        if (r_row_no == ROW_LAST) begin
                            w_state_nxt    = ST_RUN;
                            w_round_no_nxt = '0;
                        end else begin
                            w_row_no_nxt = r_row_no + RW'(1);
                        end
                    end else if (w_wrap) begin
                        if (r_round_no == ROUND_LAST) begin
                            w_state_nxt    = ST_IDLE;
                            w_row_no_nxt   = '0;
                            w_round_no_nxt = '0;
                            w_done_nxt     = 1'b1;
                        end else begin
                            w_round_no_nxt = r_round_no + NW'(1);
                        end
                    end
                end
            end
            default: begin
                w_state_nxt    = ST_IDLE;
                w_pu_addr_nxt  = '0;
                w_pu_no_nxt    = '0;
                w_row_no_nxt   = '0;
                w_round_no_nxt = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_pu_addr  <= '0;
            r_pu_no    <= '0;
            r_row_no   <= '0;
            r_round_no <= '0;
            r_done     <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_pu_addr  <= w_pu_addr_nxt;
            r_pu_no    <= w_pu_no_nxt;
            r_row_no   <= w_row_no_nxt;
            r_round_no <= w_round_no_nxt;
            r_done     <= w_done_nxt;
        end
    end

`ifdef MAP_SEQ_STEP_CNT_EN
    logic [31:0] r_step_cnt;

    // survives return to IDLE so software can read the count of the last job
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_step_cnt <= '0;
        end else if (r_state == ST_IDLE && w_state_nxt == ST_FILL) begin
            r_step_cnt <= '0;
        end else if (w_step && !abort) begin
            r_step_cnt <= r_step_cnt + 32'd1;
        end
    end

    assign step_cnt = r_step_cnt;
`endif

    assign valid    = w_step;
    assign busy     = w_busy;
    assign done     = r_done;
    assign phase    = r_state;
    assign pu_addr  = r_pu_addr;
    assign pu_no    = r_pu_no;
    assign row_no   = r_row_no;
    assign round_no = r_round_no;

endmodule

// File: tb/tb_img2col_map_sequencer.sv
// tb/tb_img2col_map_sequencer.sv - directed self-checking bench for img2col_map_sequencer
module tb_img2col_map_sequencer;

    logic clk;
    logic rst;

    // DUT A: ADDR_DEPTH=2 NUM_PU=3 FILL_ROWS=2 NUM_ROUNDS=2
    logic       a_start, a_stall, a_abort;
    logic       a_valid, a_busy, a_done;
    logic [1:0] a_phase;
    logic [0:0] a_pu_addr;
    logic [1:0] a_pu_no;
    logic [0:0] a_row_no;
    logic [0:0] a_round_no;

    // DUT B: default parameters
    logic       b_start, b_stall, b_abort;
    logic       b_valid, b_busy, b_done;
    logic [1:0] b_phase;
    logic [2:0] b_pu_addr;
    logic [4:0] b_pu_no;
    logic [2:0] b_row_no;
    logic [4:0] b_round_no;

    // DUT C: all parameters 1
    logic       c_start, c_stall, c_abort;
    logic       c_valid, c_busy, c_done;
    logic [1:0] c_phase;
    logic [0:0] c_pu_addr;
    logic [0:0] c_pu_no;
    logic [0:0] c_row_no;
    logic [0:0] c_round_no;

`ifdef MAP_SEQ_STEP_CNT_EN
    logic [31:0] a_step_cnt, b_step_cnt, c_step_cnt;
`endif

    img2col_map_sequencer #(.ADDR_DEPTH(2), .NUM_PU(3), .FILL_ROWS(2), .NUM_ROUNDS(2)) u_dut_a (
        .clk(clk), .rst(rst), .start(a_start), .stall(a_stall), .abort(a_abort),
        .valid(a_valid), .busy(a_busy), .done(a_done), .phase(a_phase),
        .pu_addr(a_pu_addr), .pu_no(a_pu_no), .row_no(a_row_no),
`ifdef MAP_SEQ_STEP_CNT_EN
        .step_cnt(a_step_cnt),
`endif
        .round_no(a_round_no)
    );

    img2col_map_sequencer u_dut_b (
        .clk(clk), .rst(rst), .start(b_start), .stall(b_stall), .abort(b_abort),
        .valid(b_valid), .busy(b_busy), .done(b_done), .phase(b_phase),
        .pu_addr(b_pu_addr), .pu_no(b_pu_no), .row_no(b_row_no),
`ifdef MAP_SEQ_STEP_CNT_EN
        .step_cnt(b_step_cnt),
`endif
        .round_no(b_round_no)
    );

    img2col_map_sequencer #(.ADDR_DEPTH(1), .NUM_PU(1), .FILL_ROWS(1), .NUM_ROUNDS(1)) u_dut_c (
        .clk(clk), .rst(rst), .start(c_start), .stall(c_stall), .abort(c_abort),
        .valid(c_valid), .busy(c_busy), .done(c_done), .phase(c_phase),
        .pu_addr(c_pu_addr), .pu_no(c_pu_no), .row_no(c_row_no),
`ifdef MAP_SEQ_STEP_CNT_EN
        .step_cnt(c_step_cnt),
`endif
        .round_no(c_round_no)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec;
    int n_bad;

    task automatic chk(input string tag, input int got, input int exp);
        n_vec++;
        if (got != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // reference for DUT A: flat step index within the job
    int a_act, a_s, a_dn, a_sc;
    int cyc, a_done_cyc, a_ndone, a_vcnt;

    task automatic cycle_a(input bit st, input bit sl, input bit ab);
        int ph, ad, pu, rw, rd, r;
        a_start = st;
        a_stall = sl;
        a_abort = ab;
        @(negedge clk);
        ph = 0; ad = 0; pu = 0; rw = 0; rd = 0;
        if (a_act != 0) begin
            if (a_s < 12) begin
                ph = 1; ad = a_s % 2; pu = (a_s / 2) % 3; rw = a_s / 6;
            end else begin
                r = a_s - 12;
                ph = 2; ad = r % 2; pu = (r / 2) % 3; rw = 1; rd = r / 6;
            end
        end
        chk("a_phase", a_phase, ph);
        chk("a_busy", a_busy, (a_act != 0) ? 1 : 0);
        chk("a_valid", a_valid, (a_act != 0 && !sl) ? 1 : 0);
        chk("a_done", a_done, a_dn);
        chk("a_pu_addr", a_pu_addr, ad);
        chk("a_pu_no", a_pu_no, pu);
        chk("a_row_no", a_row_no, rw);
        chk("a_round_no", a_round_no, rd);
`ifdef MAP_SEQ_STEP_CNT_EN
        chk("a_step_cnt", a_step_cnt, a_sc);
`endif
        if (a_done) begin
            a_done_cyc = cyc;
            a_ndone++;
        end
        if (a_valid) a_vcnt++;
        @(posedge clk);
        a_dn = 0;
        if (a_act == 0) begin
            if (st && !ab) begin
                a_act = 1; a_s = 0; a_sc = 0;
            end
        end else if (ab) begin
            a_act = 0; a_s = 0;
        end else if (!sl) begin
            a_s++;
            a_sc++;
            if (a_s == 24) begin
                a_act = 0; a_s = 0; a_dn = 1;
            end
        end
        cyc++;
        #1;
    endtask

    task automatic new_test_a();
        cyc = 0; a_done_cyc = -1; a_ndone = 0; a_vcnt = 0;
    endtask

    int c_ph[5]  = '{0, 1, 2, 0, 0};
    int c_v[5]   = '{0, 1, 1, 0, 0};
    int c_d[5]   = '{0, 0, 0, 1, 0};
    int b_cnt, b_last_v, b_done_c, b_seen_run, b_lr, b_lp, b_la;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        n_vec = 0; n_bad = 0;
        a_act = 0; a_s = 0; a_dn = 0; a_sc = 0;
        a_start = 0; a_stall = 0; a_abort = 0;
        b_start = 0; b_stall = 0; b_abort = 0;
        c_start = 0; c_stall = 0; c_abort = 0;
        rst = 1'b1;
        #1;
        chk("rst_phase", a_phase, 0);
        chk("rst_busy", a_busy, 0);
        chk("rst_valid", a_valid, 0);
        chk("rst_done", a_done, 0);
        chk("rst_b_tuple", {b_pu_addr, b_pu_no, b_row_no, b_round_no}, 0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // plain job; extra start during FILL must be ignored
        new_test_a();
        for (int c = 0; c < 30; c++) cycle_a(c == 0 || c == 5, 1'b0, 1'b0);
        chk("t1_done_cyc", a_done_cyc, 25);
        chk("t1_done_cnt", a_ndone, 1);
        chk("t1_valid_cnt", a_vcnt, 24);

        // stall cycles 5..9
        new_test_a();
        for (int c = 0; c < 35; c++) cycle_a(c == 0, c >= 5 && c <= 9, 1'b0);
        chk("t2_done_cyc", a_done_cyc, 30);
        chk("t2_valid_cnt", a_vcnt, 24);
`ifdef MAP_SEQ_STEP_CNT_EN
        chk("t2_step_cnt", a_step_cnt, 24);
`endif

        // start together with abort in IDLE
        new_test_a();
        for (int c = 0; c < 3; c++) cycle_a(c == 0, 1'b0, c == 0);
        chk("t3_no_job", a_vcnt, 0);

        // abort mid-RUN then full job from cycle 20
        new_test_a();
        for (int c = 0; c < 50; c++) cycle_a(c == 0 || c == 20, 1'b0, c == 15);
        chk("t4_done_cyc", a_done_cyc, 45);
        chk("t4_done_cnt", a_ndone, 1);
        chk("t4_valid_cnt", a_vcnt, 15 + 24);

        // async reset between edges mid-RUN
        new_test_a();
        for (int c = 0; c < 17; c++) cycle_a(c == 0, 1'b0, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        chk("t5_phase", a_phase, 0);
        chk("t5_busy", a_busy, 0);
        chk("t5_valid", a_valid, 0);
        chk("t5_done", a_done, 0);
        chk("t5_tuple", {a_pu_addr, a_pu_no, a_row_no, a_round_no}, 0);
        rst = 1'b0;
        a_act = 0; a_s = 0; a_dn = 0; a_sc = 0;
        new_test_a();
        for (int c = 0; c < 27; c++) cycle_a(c == 0, 1'b0, 1'b0);
        chk("t5_done_cyc", a_done_cyc, 25);

        // default parameters
        b_start = 1'b1;
        @(posedge clk);
        #1;
        b_start = 1'b0;
        b_cnt = 0; b_last_v = -1; b_done_c = -1; b_seen_run = 0;
        b_lr = -1; b_lp = -1; b_la = -1;
        for (int c = 1; c < 6000 && b_done_c < 0; c++) begin
            @(negedge clk);
            if (b_phase == 2'b10 && b_seen_run == 0) begin
                b_seen_run = 1;
                chk("b_last_fill_row", b_lr, 4);
                chk("b_last_fill_pu", b_lp, 27);
                chk("b_last_fill_addr", b_la, 4);
            end
            if (b_valid) begin
                b_cnt++;
                b_last_v = c;
                if (b_phase == 2'b01) begin
                    b_lr = b_row_no; b_lp = b_pu_no; b_la = b_pu_addr;
                end
            end
            if (b_done) b_done_c = c;
            @(posedge clk);
            #1;
        end
        chk("b_seen_run", b_seen_run, 1);
        chk("b_valid_cnt", b_cnt, 4620);
        chk("b_done_cyc", b_done_c, 4621);
        chk("b_done_lat", b_done_c - b_last_v, 1);
        @(negedge clk);
        chk("b_done_pulse", b_done, 0);
        chk("b_idle", b_phase, 0);
        @(posedge clk);
        #1;

        // all parameters 1
        for (int c = 0; c < 5; c++) begin
            c_start = (c == 0);
            @(negedge clk);
            chk("c_phase", c_phase, c_ph[c]);
            chk("c_valid", c_valid, c_v[c]);
            chk("c_done", c_done, c_d[c]);
            @(posedge clk);
            #1;
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
